// File: rtl/riscv_aes_result_writeback.sv
// Drains a finished 128-bit AES result block to data memory as NUM_WORDS
// sequential word stores over the req/gnt/rvalid data port.
//
// state    | meaning
// IDLE     | waiting for the AES completion pulse
// REQ      | store request for word[idx] presented until granted
// WAIT_RSP | store granted, waiting for its response
// DONE     | one-cycle completion pulse, then back to IDLE
module riscv_aes_result_writeback #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WORDS   = 4,
    parameter int ADDR_STRIDE = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            aes_done_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] aes_result_i,
    input  logic [DATA_WIDTH-1:0]           wb_addr_i,
    output logic                            data_req_o,
    input  logic                            data_gnt_i,
    input  logic                            data_rvalid_i,
    output logic [DATA_WIDTH-1:0]           data_addr_o,
    output logic [DATA_WIDTH-1:0]           data_wdata_o,
    output logic                            data_we_o,
    output logic [3:0]                      data_be_o,
    output logic                            busy_o,
    output logic                            wb_done_o,
    output logic                            overrun_o
);
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int BLK_W = NUM_WORDS * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [BLK_W-1:0]        result;
    logic [DATA_WIDTH-1:0]   base;
    logic                    busy;
    logic                    overrun;
    logic                    last_word;
    logic                    accept;

    assign last_word = (idx == IDX_W'(NUM_WORDS - 1));
    assign accept    = (state == IDLE) && aes_done_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            result  <= '0;
            base    <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != IDLE);
            // A completion pulse outside IDLE is dropped but reported.
            overrun <= aes_done_i && (state != IDLE);
            if (accept) begin
                result <= aes_result_i;
                base   <= wb_addr_i & ~DATA_WIDTH'(3);
                idx    <= '0;
            end else if ((state == WAIT_RSP) && data_rvalid_i && !last_word) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        wb_done_o    = 1'b0;
        case (state)
            IDLE: begin
                if (aes_done_i) state_nxt = REQ;
            end
            REQ: begin
                data_req_o   = 1'b1;
                data_we_o    = 1'b1;
                data_be_o    = 4'hF;
                // Address arithmetic wraps silently at the top of the space.
                data_addr_o  = base + DATA_WIDTH'(idx) * DATA_WIDTH'(ADDR_STRIDE);
                data_wdata_o = result[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
                if (data_gnt_i) state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (data_rvalid_i) state_nxt = last_word ? DONE : REQ;
            end
            DONE: begin
                wb_done_o = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o    = busy;
    assign overrun_o = overrun;

endmodule

// File: tb/tb_riscv_aes_result_writeback.sv
// Scoreboard bench for riscv_aes_result_writeback: expected stores are queued
// at issue time and a monitor checks every granted store against them.
`timescale 1ns/1ps
module tb_riscv_aes_result_writeback;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          aes_done_i = 1'b0;
    logic [127:0]  aes_result_i = '0;
    logic [31:0]   wb_addr_i = '0;
    logic          data_req_o;
    logic          data_gnt_i = 1'b0;
    logic          data_rvalid_i = 1'b0;
    logic [31:0]   data_addr_o;
    logic [31:0]   data_wdata_o;
    logic          data_we_o;
    logic [3:0]    data_be_o;
    logic          busy_o;
    logic          wb_done_o;
    logic          overrun_o;

    riscv_aes_result_writeback dut (
        .clk(clk), .rst_n(rst_n), .aes_done_i(aes_done_i), .aes_result_i(aes_result_i),
        .wb_addr_i(wb_addr_i), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .busy_o(busy_o),
        .wb_done_o(wb_done_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } store_t;
    store_t exp_q[$];

    int errors = 0, checks = 0, cycle = 0;
    int rsp_count = 0, gnt_count = 0, rsp_delay = 1, gnt_pct = 100;
    int stall_at = -1, stall_len = 0;
    int done_seen = 0, ovr_seen = 0, exp_done = 0, exp_ovr = 0;
    int issue_cycle = 0;

    always @(posedge clk) cycle++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Memory model: grants with probability gnt_pct, responds rsp_delay cycles later.
    initial begin : responder
        int  pend;
        bit  gnt_prev;
        pend = 0;
        gnt_prev = 0;
        forever begin
            @(posedge clk); #1;
            data_rvalid_i = 1'b0;
            data_gnt_i = 1'b0;
            if (gnt_prev) pend = rsp_delay;
            gnt_prev = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    data_rvalid_i = 1'b1;
                    rsp_count++;
                end
            end else if (data_req_o) begin
                if (gnt_count == stall_at && stall_len > 0) stall_len--;
                else if ($urandom_range(99) < gnt_pct) begin
                    data_gnt_i = 1'b1;
                    gnt_prev = 1;
                    gnt_count++;
                end
            end
        end
    end

    initial begin : monitor
        bit          pend_req;
        logic [31:0] pa, pd;
        store_t      e;
        pend_req = 0;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (wb_done_o) done_seen++;
            if (overrun_o) ovr_seen++;
            if (data_req_o) begin
                chk("req_we_be", {27'b0, data_we_o, data_be_o}, 32'h1F);
                if (pend_req) begin
                    chk("stable_addr", data_addr_o, pa);
                    chk("stable_wdata", data_wdata_o, pd);
                end
                if (data_gnt_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_store: got addr %h data %h, required no store", data_addr_o, data_wdata_o);
                    end else begin
                        checks--;
                        e = exp_q.pop_front();
                        chk("store_addr", data_addr_o, e.addr);
                        chk("store_data", data_wdata_o, e.data);
                    end
                    pend_req = 0;
                end else begin
                    pend_req = 1;
                    pa = data_addr_o;
                    pd = data_wdata_o;
                end
            end else begin
                if (pend_req && rst_n) begin
                    checks++;
                    errors++;
                    $display("FAIL req_dropped: got req 0 before gnt, required 1");
                end
                chk("idle_we_be", {27'b0, data_we_o, data_be_o}, 32'h0);
                pend_req = 0;
            end
        end
    end

    // Pulse aes_done_i for one cycle; accepted blocks queue their four stores.
    task automatic issue(input logic [31:0] addr, input logic [127:0] blk, input bit accept);
        store_t s;
        @(posedge clk); #1;
        issue_cycle = cycle;
        aes_done_i = 1'b1;
        wb_addr_i = addr;
        aes_result_i = blk;
        if (accept) begin
            for (int k = 0; k < 4; k++) begin
                s.addr = {addr[31:2], 2'b00} + 32'(4 * k);
                s.data = blk[32*k +: 32];
                exp_q.push_back(s);
            end
        end else begin
            exp_ovr++;
        end
        @(posedge clk); #1;
        aes_done_i = 1'b0;
        wb_addr_i = $urandom;
        aes_result_i = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("overrun", 32'(overrun_o), 32'(!accept));
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_count < target) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL wait_rsp: got %0d responses, required %0d (timeout)", rsp_count, target);
                return;
            end
        end
    endtask

    task automatic wait_gnt(input int target);
        int n = 0;
        while (gnt_count < target) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL wait_gnt: got %0d grants, required %0d (timeout)", gnt_count, target);
                return;
            end
        end
    endtask

    // Called at the negedge of the last response cycle; checks the DONE cycle.
    task automatic check_done(input int latency);
        @(negedge clk);
        chk("wb_done", 32'(wb_done_o), 32'd1);
        chk("busy_in_done", 32'(busy_o), 32'd1);
        if (latency >= 0) chk("done_latency", 32'(cycle - issue_cycle), 32'(latency));
        exp_done++;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_req"}, 32'(data_req_o), 32'd0);
        chk({name, "_busy"}, 32'(busy_o), 32'd0);
        chk({name, "_done"}, 32'(wb_done_o), 32'd0);
        chk({name, "_ovr"}, 32'(overrun_o), 32'd0);
        chk({name, "_addr"}, data_addr_o, 32'd0);
        chk({name, "_wdata"}, data_wdata_o, 32'd0);
        chk({name, "_we_be"}, {27'b0, data_we_o, data_be_o}, 32'd0);
    endtask

    localparam logic [127:0] BLK1 = 128'h33333333_22222222_11111111_00000000;

    initial begin : stimulus
        int tgt, gb, snap;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic writeback with exact cycle timeline
        gnt_pct = 100;
        rsp_delay = 1;
        issue(32'h0000_1000, BLK1, 1);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            chk("t1_req", 32'(data_req_o), 32'((c % 2 == 1) && (c <= 7)));
            chk("t1_busy", 32'(busy_o), 32'(c <= 9));
            chk("t1_done", 32'(wb_done_o), 32'(c == 9));
        end
        exp_done++;

        // Gnt backpressure on word 2
        tgt = rsp_count + 4;
        stall_at = gnt_count + 2;
        stall_len = 5;
        issue(32'h0000_1000, BLK1, 1);
        wait_rsp(tgt);
        check_done(14);

        // Misaligned base with wrap
        tgt = rsp_count + 4;
        issue(32'hFFFF_FFFB, {$urandom, $urandom, $urandom, $urandom}, 1);
        wait_rsp(tgt);
        check_done(9);

        // Overrun during word 1
        tgt = rsp_count + 4;
        issue(32'h0000_2000, {$urandom, $urandom, $urandom, $urandom}, 1);
        wait_rsp(tgt - 3);
        issue(32'h0000_3000, {$urandom, $urandom, $urandom, $urandom}, 0);
        wait_rsp(tgt);
        check_done(-1);

        // Overrun while in DONE
        tgt = rsp_count + 4;
        issue(32'h0000_4000, {$urandom, $urandom, $urandom, $urandom}, 1);
        wait_rsp(tgt);
        issue(32'h0000_5000, {$urandom, $urandom, $urandom, $urandom}, 0);
        exp_done++;

        // Reset in WAIT_RSP of word 1, response arrives after release
        rsp_delay = 4;
        gb = gnt_count;
        issue(32'h0000_6000, {$urandom, $urandom, $urandom, $urandom}, 1);
        wait_gnt(gb + 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        snap = done_seen;
        repeat (8) @(negedge clk);
        chk("late_rvalid_no_done", 32'(done_seen), 32'(snap));
        chk("late_rvalid_idle", 32'(busy_o), 32'd0);
        rsp_delay = 1;
        tgt = rsp_count + 4;
        issue(32'h0000_7000, {$urandom, $urandom, $urandom, $urandom}, 1);
        wait_rsp(tgt);
        check_done(9);

        // Back-to-back blocks
        tgt = rsp_count + 4;
        issue(32'h0000_8000, {$urandom, $urandom, $urandom, $urandom}, 1);
        wait_rsp(tgt);
        check_done(9);
        tgt = rsp_count + 4;
        issue(32'h0000_9000, {$urandom, $urandom, $urandom, $urandom}, 1);
        wait_rsp(tgt);
        check_done(9);

        // Randomized blocks with random handshake timing and overruns
        for (int b = 0; b < 25; b++) begin
            gnt_pct = $urandom_range(100, 40);
            rsp_delay = $urandom_range(3, 1);
            tgt = rsp_count + 4;
            issue($urandom, {$urandom, $urandom, $urandom, $urandom}, 1);
            if ($urandom_range(3) == 0) begin
                wait_rsp(tgt - $urandom_range(3, 2));
                issue($urandom, {$urandom, $urandom, $urandom, $urandom}, 0);
            end
            wait_rsp(tgt);
            if ($urandom_range(4) == 0) begin
                issue($urandom, {$urandom, $urandom, $urandom, $urandom}, 0);
                exp_done++;
            end else begin
                check_done(-1);
                repeat ($urandom_range(3)) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        chk("leftover_stores", 32'(exp_q.size()), 32'd0);
        chk("wb_done_total", 32'(done_seen), 32'(exp_done));
        chk("overrun_total", 32'(ovr_seen), 32'(exp_ovr));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule

// File: doc/riscv_aes_result_writeback.md
Name: riscv_aes_result_writeback

Overview:
Drains the 128-bit AES result from the AES core back to data memory. It takes the core's completion pulse and the writeback address programmed by software, then issues four sequential 32-bit stores on the core's data-memory request port. The port uses the req/gnt/rvalid handshake. The block sits between the AES datapath and the LSU/data-memory arbiter. It is the outbound counterpart of the AES register file, which loads state and key words into the accelerator.

Parameters:
DATA_WIDTH, 32, width of one stored word and of the address.
NUM_WORDS, 4, words per AES block; the word index counter is clog2(NUM_WORDS) bits.
ADDR_STRIDE, 4, byte increment between consecutive stores.

Ports:
clk  input  1  clock.
rst_n  input  1  reset; synchronous, active-low.
aes_done_i  input  1  one-cycle pulse from the AES core: result valid.
aes_result_i  input  NUM_WORDS*DATA_WIDTH  result block; word k = bits [32k+31:32k].
wb_addr_i  input  DATA_WIDTH  base byte address from the AES register file.
data_req_o  output  1  memory request.
data_gnt_i  input  1  request accepted.
data_rvalid_i  input  1  store response.
data_addr_o  output  DATA_WIDTH  store address.
data_wdata_o  output  DATA_WIDTH  store data.
data_we_o  output  1  write enable; always 1 while data_req_o is 1, otherwise 0.
data_be_o  output  4  byte enables; 4'hF while data_req_o is 1, otherwise 0.
busy_o  output  1  writeback in progress.
wb_done_o  output  1  one-cycle completion pulse.
overrun_o  output  1  one-cycle pulse: aes_done_i arrived while busy.

Behaviour:
- Only one clock domain. All state is updated on posedge clk.
- Reset when rst_n==0 at a clock edge. Reset drives:
  - state=IDLE, word index=0, latched result=0, latched base=0;
  - all outputs 0.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - On aes_done_i=1, latch aes_result_i and the base address. The latched base is wb_addr_i with bits [1:0] forced to 0.
  - Set index=0 and go to REQ.
  - data_rvalid_i and data_gnt_i are ignored in IDLE.
- REQ:
  - data_req_o=1.
  - data_addr_o = base + index*ADDR_STRIDE, computed modulo 2^DATA_WIDTH; wrap past 32'hFFFFFFFC is silent.
  - data_wdata_o = latched word[index].
  - Address, data, we and be stay stable until the gnt cycle.
  - On data_gnt_i=1, go to WAIT_RSP; otherwise stay in REQ.
- WAIT_RSP:
  - data_req_o=0. Only one transaction is outstanding at a time.
  - On data_rvalid_i=1: if index==NUM_WORDS-1, go to DONE; otherwise index+1 and go to REQ.
- DONE:
  - wb_done_o=1 for exactly one cycle, then go to IDLE.
- busy_o is registered: 1 in REQ, WAIT_RSP and DONE; 0 in IDLE.
- Latency with gnt granted on the first req cycle and rvalid on the next cycle:
  - aes_done_i at cycle 0 → data_req_o rises at cycle 1;
  - words are issued at cycles 1, 3, 5, 7;
  - wb_done_o at cycle 9; busy_o high for cycles 1–9.
- Without further handshake stalls, a new aes_done_i is accepted in IDLE at cycle 10.
- aes_done_i while not in IDLE (including DONE):
  - the pulse is ignored;
  - latched data and base are untouched;
  - overrun_o pulses in the next cycle.
- aes_result_i and wb_addr_i changing after the latch cycle have no effect.
- Reset asserted mid-transfer:
  - data_req_o drops at that edge and the FSM returns to IDLE;
  - a late rvalid arriving after reset is ignored.
- data_rvalid_i arriving in REQ is ignored.

Test Plan:
1. Basic writeback:
   - Stimulus: wb_addr_i=32'h0000_1000, result=128'h33333333_22222222_11111111_00000000, gnt immediate, rvalid one cycle later.
   - Required: stores (1000,00000000), (1004,11111111), (1008,22222222), (100C,33333333) in that order; wb_done_o at cycle 9; busy_o low at cycle 10.
2. Gnt backpressure:
   - Stimulus: hold data_gnt_i=0 for 5 cycles on word 2.
   - Required: data_req_o stays high with addr=1008 and wdata=22222222 stable throughout; no extra store; wb_done_o delayed by 5 cycles.
3. Misaligned base and address wrap:
   - Stimulus: wb_addr_i=32'hFFFF_FFFB.
   - Required: addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
4. Overrun:
   - Stimulus: second aes_done_i during word 1 with a different result and address.
   - Required: overrun_o pulses once; all four stores still use the first block and first address; the second block is never written.
5. Reset mid-operation:
   - Stimulus: rst_n=0 while in WAIT_RSP of word 1, then an rvalid arrives after release.
   - Required: all outputs 0 at the next edge; the late rvalid causes no store and no wb_done_o; a fresh aes_done_i performs a full 4-word writeback.
6. Back-to-back blocks:
   - Stimulus: second aes_done_i in the first IDLE cycle after wb_done_o.
   - Required: accepted with no overrun_o; 8 stores total, in order.
